// File: rtl/frame_pixel_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_pixel_writer_if
// Brief    : Write-window / SRAM-write bus between the pixel engine (master)
//            and the SRAM controller (slave). The tri-stated pixel word stays
//            a plain port on the engine.
// Revision : 1.0 - initial release
// ============================================================================
interface frame_pixel_writer_if #(
  parameter int ADDR_W = 16
);
  logic              write;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              frame_done;

  modport master (
    input  write,
    output mem_addr,
    output mem_we,
    output frame_done
  );

  modport slave (
    output write,
    input  mem_addr,
    input  mem_we,
    input  frame_done
  );
endinterface
`default_nettype wire

// File: rtl/frame_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : frame_pixel_writer
// Brief    : Raster-order framebuffer write engine. Emits one pixel word plus
//            its linear SRAM address per write cycle, drawing background,
//            a platform band and N_OBJ ball sprites with fixed priority.
// Options  : FRAME_LATCH_EN - sprite inputs are shadowed at pixel (0,0) so a
//            whole frame is drawn from one consistent set of positions.
// Revision : 1.0 - initial release
// ============================================================================
module frame_pixel_writer #(
  parameter int              H_CELLS    = 100,
  parameter int              V_LINES    = 600,
  parameter int              DATA_W     = 6,
  parameter int              N_OBJ      = 2,
  parameter int              PLAT_TOP   = 500,
  parameter int              PLAT_BOT   = 519,
  parameter logic [DATA_W-1:0] PLAT_COLOR = 6'b001100,
  parameter logic [DATA_W-1:0] BG_COLOR   = 6'b110100
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  frame_pixel_writer_if.master         bus,
  input  wire logic [N_OBJ*7-1:0]      obj_x,
  input  wire logic [N_OBJ*10-1:0]     obj_y,
  input  wire logic [N_OBJ-1:0]        obj_en,
  input  wire logic [N_OBJ*DATA_W-1:0] obj_color,
  output wire       [DATA_W-1:0]       mem_data
);

  localparam int c_ADDR_W = $clog2(H_CELLS * V_LINES);
  localparam int c_COL_W  = $clog2(H_CELLS);
  localparam int c_ROW_W  = $clog2(V_LINES);

  localparam logic [c_COL_W-1:0]  c_COL_LAST  = c_COL_W'(H_CELLS - 1);
  localparam logic [c_ROW_W-1:0]  c_ROW_LAST  = c_ROW_W'(V_LINES - 1);
  localparam logic [c_ADDR_W-1:0] c_ADDR_LAST = c_ADDR_W'(H_CELLS * V_LINES - 1);
  localparam logic [c_ROW_W-1:0]  c_PLAT_TOP  = c_ROW_W'(PLAT_TOP);
  localparam logic [c_ROW_W-1:0]  c_PLAT_BOT  = c_ROW_W'(PLAT_BOT);

  logic [c_COL_W-1:0]  r_col;
  logic [c_ROW_W-1:0]  r_row;
  logic [c_ADDR_W-1:0] r_lin;

  logic                r_mem_we;
  logic [c_ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0]   r_mem_data_q;
  logic                r_frame_done;

  logic [N_OBJ*7-1:0]      w_obj_x;
  logic [N_OBJ*10-1:0]     w_obj_y;
  logic [N_OBJ-1:0]        w_obj_en;
  logic [N_OBJ*DATA_W-1:0] w_obj_color;
  logic [N_OBJ-1:0]        w_hit;
  logic                    w_plat;
  logic [DATA_W-1:0]       w_color;

  // Ball outline: half-width of the sprite as a function of the line offset.
  // dx/dy are 11-bit signed so sprites near an edge never alias across it.
  function automatic logic f_covered(input logic signed [10:0] dx,
                                     input logic signed [10:0] dy);
    logic signed [10:0] hw;
    hw = 11'sd0;
    if      (dy > -11'sd24 && dy <= -11'sd20) hw = 11'sd3;
    else if (dy > -11'sd20 && dy <= -11'sd12) hw = 11'sd5;
    else if (dy > -11'sd12 && dy <=  11'sd12) hw = 11'sd6;
    else if (dy >  11'sd12 && dy <=  11'sd20) hw = 11'sd5;
    else if (dy >  11'sd20 && dy <=  11'sd24) hw = 11'sd3;
    return (dx > -hw) && (dx <= hw);
  endfunction

  // Raster position and linear address advance together on every write cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
      r_lin <= '0;
    end else if (bus.write) begin
      if (r_col == c_COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      r_lin <= (r_lin == c_ADDR_LAST) ? '0 : r_lin + 1'b1;
    end
  end

`ifdef FRAME_LATCH_EN
  logic [N_OBJ*7-1:0]      r_obj_x;
  logic [N_OBJ*10-1:0]     r_obj_y;
  logic [N_OBJ-1:0]        r_obj_en;
  logic [N_OBJ*DATA_W-1:0] r_obj_color;
  logic                    w_first;

  assign w_first = bus.write && (r_lin == '0);

  // Shadow the sprite inputs on the write cycle of pixel (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_obj_x     <= '0;
      r_obj_y     <= '0;
      r_obj_en    <= '0;
      r_obj_color <= '0;
    end else if (w_first) begin
      r_obj_x     <= obj_x;
      r_obj_y     <= obj_y;
      r_obj_en    <= obj_en;
      r_obj_color <= obj_color;
    end
  end

  // Pixel (0,0) already sees the values being captured
  assign w_obj_x     = w_first ? obj_x     : r_obj_x;
  assign w_obj_y     = w_first ? obj_y     : r_obj_y;
  assign w_obj_en    = w_first ? obj_en    : r_obj_en;
  assign w_obj_color = w_first ? obj_color : r_obj_color;
`else
  assign w_obj_x     = obj_x;
  assign w_obj_y     = obj_y;
  assign w_obj_en    = obj_en;
  assign w_obj_color = obj_color;
`endif

  for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_obj
    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    assign w_dx      = $signed(11'(r_col)) - $signed(11'(w_obj_x[7*gi +: 7]));
    assign w_dy      = $signed(11'(r_row)) - $signed(11'(w_obj_y[10*gi +: 10]));
    assign w_hit[gi] = w_obj_en[gi] && f_covered(w_dx, w_dy);
  end

  assign w_plat = (r_row >= c_PLAT_TOP) && (r_row <= c_PLAT_BOT);

  // Colour priority: platform, then lowest-index covering object, then background
  always_comb begin
    w_color = BG_COLOR;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (w_hit[i]) w_color = w_obj_color[i*DATA_W +: DATA_W];
    end
    if (w_plat) w_color = PLAT_COLOR;
  end

  // Single output register stage; strobe follows write by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data_q <= BG_COLOR;
      r_frame_done <= 1'b0;
    end else begin
      r_mem_we     <= bus.write;
      r_frame_done <= bus.write && (r_lin == c_ADDR_LAST);
      if (bus.write) begin
        r_mem_addr   <= r_lin;
        r_mem_data_q <= w_color;
      end
    end
  end

  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.frame_done = r_frame_done;
  assign mem_data       = r_mem_we ? r_mem_data_q : 'z;

endmodule
`default_nettype wire

// File: tb/tb_frame_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_pixel_writer
// Brief    : Self-checking bench for frame_pixel_writer against a pixel-rule
//            reference model (raster index, platform band, sprite outline).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_pixel_writer;

  localparam int H    = 100;
  localparam int V    = 600;
  localparam int NPIX = H * V;
  localparam int DW   = 6;
  localparam int NO   = 2;
  localparam int PTOP = 500;
  localparam int PBOT = 519;
  localparam logic [DW-1:0] PLAT = 6'b001100;
  localparam logic [DW-1:0] BG   = 6'b110100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [NO*7-1:0]  obj_x;
  logic [NO*10-1:0] obj_y;
  logic [NO-1:0]    obj_en;
  logic [NO*DW-1:0] obj_color;
  wire  [DW-1:0]    mem_data;

  frame_pixel_writer_if #(.ADDR_W(16)) bus ();

  frame_pixel_writer #(
    .H_CELLS(H), .V_LINES(V), .DATA_W(DW), .N_OBJ(NO),
    .PLAT_TOP(PTOP), .PLAT_BOT(PBOT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .obj_x(obj_x), .obj_y(obj_y), .obj_en(obj_en), .obj_color(obj_color),
    .mem_data(mem_data)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_idx;
  int          e_x [NO];
  int          e_y [NO];
  logic        e_en[NO];
  logic [DW-1:0] e_c[NO];
`ifdef FRAME_LATCH_EN
  int          sh_x [NO];
  int          sh_y [NO];
  logic        sh_en[NO];
  logic [DW-1:0] sh_c[NO];
`endif

  logic          exp_we;
  logic          exp_done;
  logic [15:0]   exp_addr;
  logic [DW-1:0] exp_data;

  function automatic int half_width(input int dy);
    if (dy > -24 && dy <= -20) return 3;
    if (dy > -20 && dy <= -12) return 5;
    if (dy > -12 && dy <=  12) return 6;
    if (dy >  12 && dy <=  20) return 5;
    if (dy >  20 && dy <=  24) return 3;
    return 0;
  endfunction

  function automatic logic [DW-1:0] ref_color(input int col, input int row);
    int hw;
    if (row >= PTOP && row <= PBOT) return PLAT;
    for (int i = 0; i < NO; i++) begin
      hw = half_width(row - e_y[i]);
      if (e_en[i] && hw > 0 && (col - e_x[i]) > -hw && (col - e_x[i]) <= hw)
        return e_c[i];
    end
    return BG;
  endfunction

  task automatic model_reset();
    m_idx = 0;
`ifdef FRAME_LATCH_EN
    for (int i = 0; i < NO; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 1'b0; sh_c[i] = '0;
    end
`endif
  endtask

  // Drive one cycle of write and compute what the DUT must show after it
  task automatic drive_cycle(input logic w);
    bus.write = w;
    exp_we    = w;
    exp_done  = 1'b0;
    if (w) begin
      for (int i = 0; i < NO; i++) begin
`ifdef FRAME_LATCH_EN
        if (m_idx == 0) begin
          sh_x[i]  = int'(obj_x[7*i +: 7]);
          sh_y[i]  = int'(obj_y[10*i +: 10]);
          sh_en[i] = obj_en[i];
          sh_c[i]  = obj_color[DW*i +: DW];
        end
        e_x[i] = sh_x[i]; e_y[i] = sh_y[i]; e_en[i] = sh_en[i]; e_c[i] = sh_c[i];
`else
        e_x[i]  = int'(obj_x[7*i +: 7]);
        e_y[i]  = int'(obj_y[10*i +: 10]);
        e_en[i] = obj_en[i];
        e_c[i]  = obj_color[DW*i +: DW];
`endif
      end
      exp_addr = 16'(m_idx);
      exp_data = ref_color(m_idx % H, m_idx / H);
      exp_done = (m_idx == NPIX - 1);
      m_idx    = (m_idx + 1) % NPIX;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_obj(input int i, input int x, input int y,
                         input logic en, input logic [DW-1:0] c);
    obj_x[7*i +: 7]      = 7'(x);
    obj_y[10*i +: 10]    = 10'(y);
    obj_en[i]            = en;
    obj_color[DW*i +: DW] = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.write = 1'b0;
    obj_x = '0; obj_y = '0; obj_en = '0; obj_color = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", bus.mem_we); end
    n_checks++;
    if (bus.mem_addr !== 16'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", bus.mem_addr); end
    n_checks++;
    if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.frame_done); end
    #4 rst_n = 1'b1;
    model_reset();
    drive_cycle(1'b0);
    n_checks++;
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_we got=%b exp=0", bus.mem_we); end
  endtask

  task automatic test_pause();
    logic pat[4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      drive_cycle(1'b1);
      n_checks++;
      if (bus.mem_addr !== exp_addr || mem_data !== exp_data) begin
        n_fail++;
        $display("FAIL line0_pix got addr=%0d data=%b exp addr=%0d data=%b",
                 bus.mem_addr, mem_data, exp_addr, exp_data);
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive_cycle(pat[k]);
      n_checks++;
      if (bus.mem_we !== pat[k]) begin
        n_fail++; $display("FAIL pause_we step=%0d got=%b exp=%b", k, bus.mem_we, pat[k]);
      end
      if (pat[k]) begin
        n_checks++;
        if (bus.mem_addr !== ((k == 0) ? 16'd40 : 16'd41) || mem_data !== exp_data) begin
          n_fail++;
          $display("FAIL pause_pix step=%0d got addr=%0d data=%b exp addr=%0d data=%b",
                   k, bus.mem_addr, mem_data, (k == 0) ? 40 : 41, exp_data);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    set_obj(0, $urandom_range(0, 99), $urandom_range(0, 25), 1'b1, 6'($urandom));
    set_obj(1, 0, 0, 1'b0, 6'b110000);
    while (m_idx < 25 * H) begin
      drive_cycle(1'b1);
      n_checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== exp_addr || mem_data !== exp_data) begin
        n_fail++;
        $display("FAIL top_pix got we=%b addr=%0d data=%b exp we=1 addr=%0d data=%b",
                 bus.mem_we, bus.mem_addr, mem_data, exp_addr, exp_data);
      end
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'd0 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got we=%b addr=%0d done=%b exp we=0 addr=0 done=0",
               bus.mem_we, bus.mem_addr, bus.frame_done);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL held_reset_we got=%b exp=0", bus.mem_we); end
    #4 rst_n = 1'b1;
    drive_cycle(1'b1);
    n_checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'd0 || mem_data !== exp_data) begin
      n_fail++;
      $display("FAIL first_after_reset got we=%b addr=%0d data=%b exp we=1 addr=0 data=%b",
               bus.mem_we, bus.mem_addr, mem_data, exp_data);
    end
  endtask

  task automatic test_full_frame();
    int   cyc = 0;
    int   done_cnt = 0;
    logic moved = 1'b0;
    logic wrapped = 1'b0;
    logic w;
    set_obj(0, 50, 300, 1'b1, 6'b000011);
    set_obj(1, 80, 330, 1'b1, 6'b110000);
    while (!wrapped && cyc < 90000) begin
      if (!moved && m_idx >= 200 * H) begin
        set_obj(1, 97, 510, 1'b1, 6'b110000);
        moved = 1'b1;
      end
      w = ($urandom_range(0, 9) != 0);
      drive_cycle(w);
      cyc++;
      n_checks++;
      if (bus.mem_we !== exp_we) begin
        n_fail++; $display("FAIL frame_we cyc=%0d got=%b exp=%b", cyc, bus.mem_we, exp_we);
      end
      if (exp_we) begin
        n_checks++;
        if (bus.mem_addr !== exp_addr || mem_data !== exp_data) begin
          n_fail++;
          $display("FAIL frame_pix got addr=%0d data=%b exp addr=%0d data=%b",
                   bus.mem_addr, mem_data, exp_addr, exp_data);
        end
      end
      n_checks++;
      if (bus.frame_done !== exp_done) begin
        n_fail++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, bus.frame_done, exp_done);
      end
      if (bus.frame_done === 1'b1) done_cnt++;
      if (w && m_idx == 0) wrapped = 1'b1;
    end
    n_checks++;
    if (!wrapped) begin n_fail++; $display("FAIL frame_timeout got wrapped=0 exp wrapped=1"); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_overlap_edge();
    int   cyc = 0;
    logic moved = 1'b0;
    logic w;
    set_obj(0, 2, 30, 1'b1, 6'b000011);
    set_obj(1, 2, 30, 1'b1, 6'b110000);
    while (m_idx < 56 * H && cyc < 20000) begin
      if (!moved && m_idx >= 20 * H) begin
        set_obj(0, 60, 30, 1'b1, 6'b000011);
        moved = 1'b1;
      end
      w = ($urandom_range(0, 9) != 0);
      drive_cycle(w);
      cyc++;
      n_checks++;
      if (bus.mem_we !== exp_we) begin
        n_fail++; $display("FAIL overlap_we cyc=%0d got=%b exp=%b", cyc, bus.mem_we, exp_we);
      end
      if (exp_we) begin
        n_checks++;
        if (bus.mem_addr !== exp_addr || mem_data !== exp_data || bus.frame_done !== 1'b0) begin
          n_fail++;
          $display("FAIL overlap_pix got addr=%0d data=%b done=%b exp addr=%0d data=%b done=0",
                   bus.mem_addr, mem_data, bus.frame_done, exp_addr, exp_data);
        end
      end
    end
    n_checks++;
    if (m_idx < 56 * H) begin n_fail++; $display("FAIL overlap_timeout got idx=%0d exp=%0d", m_idx, 56 * H); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_pause();
    test_async_reset();
    test_full_frame();
    test_overlap_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
